// File: rtl/re_ram_nvm_ctrl_if.sv
// Request/response bundle between a requester and the ReRAM program-and-verify controller.
interface re_ram_nvm_ctrl_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 8,
   parameter int MAX_RETRY  = 3
);
   localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

   logic                    req_valid;
   logic                    req_ready;
   logic                    req_we;
   logic [ADDR_WIDTH-1:0]   req_addr;
   logic [DATA_WIDTH-1:0]   req_wdata;
   logic [DATA_WIDTH/8-1:0] req_wstrb;
   logic                    resp_valid;
   logic [DATA_WIDTH-1:0]   resp_rdata;
   logic                    resp_err;
   logic [RW-1:0]           resp_retries;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, req_wstrb,
      input  req_ready, resp_valid, resp_rdata, resp_err, resp_retries
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, req_wstrb,
      output req_ready, resp_valid, resp_rdata, resp_err, resp_retries
   );
endinterface

// File: rtl/re_ram_nvm_ctrl.sv
// ReRAM word store with program/verify/retry writes; reads answer READ_LAT edges after accept, writes (WRITE_LAT+1) per attempt.
// req_ready only in IDLE (requests otherwise ignored); one-cycle resp_valid with no backpressure.
module re_ram_nvm_ctrl #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 8,
   parameter int READ_LAT   = 2,
   parameter int WRITE_LAT  = 4,
   parameter int MAX_RETRY  = 3,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   re_ram_nvm_ctrl_if.slave     bus,
   input  logic                 fault_inj,
   output logic [CNT_WIDTH-1:0] wear_cnt
);
   localparam int NB   = DATA_WIDTH / 8;
   localparam int RW   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
   localparam int LMAX = (READ_LAT > WRITE_LAT) ? READ_LAT : WRITE_LAT;
   localparam int CW   = $clog2(LMAX + 1);

   typedef enum logic [1:0] {IDLE, READ, PROG, VERIFY} state_t;

   state_t                state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [RW-1:0]         retry_q, retry_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] target_q, target_d;
   logic                  resp_valid_q, resp_valid_d;
   logic [DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d;
   logic                  resp_err_q, resp_err_d;
   logic [RW-1:0]         resp_retries_q, resp_retries_d;
   logic [CNT_WIDTH-1:0]  wear_q, wear_d;

   // Cell array has no reset: contents are non-volatile across rst.
   logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
   logic                  mem_we;
   logic [DATA_WIDTH-1:0] merged;

   always_comb begin
      merged = mem_q[bus.req_addr];
      for (int b = 0; b < NB; b++) begin
         if (bus.req_wstrb[b]) merged[b*8 +: 8] = bus.req_wdata[b*8 +: 8];
      end
   end

   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      retry_d        = retry_q;
      addr_d         = addr_q;
      target_d       = target_q;
      resp_valid_d   = 1'b0;
      resp_rdata_d   = resp_rdata_q;
      resp_err_d     = resp_err_q;
      resp_retries_d = resp_retries_q;
      wear_d         = wear_q;
      mem_we         = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.req_valid) begin
               addr_d = bus.req_addr;
               cnt_d  = '0;
               if (bus.req_we) begin
                  target_d = merged;
                  retry_d  = '0;
                  state_d  = PROG;
               end else begin
                  state_d  = READ;
               end
            end
         end
         READ: begin
            if (cnt_q == CW'(READ_LAT - 1)) begin
               state_d      = IDLE;
               resp_valid_d = 1'b1;
               resp_rdata_d = mem_q[addr_q];
               resp_err_d   = 1'b0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         PROG: begin
            if (wear_q != '1) wear_d = wear_q + 1'b1;
            if (cnt_q == CW'(WRITE_LAT - 1)) begin
               mem_we  = !fault_inj;
               state_d = VERIFY;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         VERIFY: begin
            if (mem_q[addr_q] == target_q || retry_q == RW'(MAX_RETRY)) begin
               state_d        = IDLE;
               resp_valid_d   = 1'b1;
               resp_err_d     = (mem_q[addr_q] != target_q);
               resp_retries_d = retry_q;
            end else begin
               retry_d = retry_q + 1'b1;
               cnt_d   = '0;
               state_d = PROG;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q        <= IDLE;
         cnt_q          <= '0;
         retry_q        <= '0;
         addr_q         <= '0;
         target_q       <= '0;
         resp_valid_q   <= 1'b0;
         resp_rdata_q   <= '0;
         resp_err_q     <= 1'b0;
         resp_retries_q <= '0;
         wear_q         <= '0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         retry_q        <= retry_d;
         addr_q         <= addr_d;
         target_q       <= target_d;
         resp_valid_q   <= resp_valid_d;
         resp_rdata_q   <= resp_rdata_d;
         resp_err_q     <= resp_err_d;
         resp_retries_q <= resp_retries_d;
         wear_q         <= wear_d;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) mem_q[addr_q] <= target_q;
   end

   assign bus.req_ready    = (state_q == IDLE);
   assign bus.resp_valid   = resp_valid_q;
   assign bus.resp_rdata   = resp_rdata_q;
   assign bus.resp_err     = resp_err_q;
   assign bus.resp_retries = resp_retries_q;
   assign wear_cnt         = wear_q;
endmodule
